// File: rtl/babbage_engine_param.sv
// babbage_engine_param: parametrised polynomial difference engine.
// Optional macro BABBAGE_STREAM_EN adds a p(0)..p(n) value stream.
module babbage_engine_param #(
    parameter int DEGREE  = 5,
    parameter int WIDTH   = 32,
    parameter int N_WIDTH = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic        [N_WIDTH-1:0] n,
    input  logic                      coef_we,
    input  logic        [3:0]         coef_addr,
    input  logic signed [WIDTH-1:0]   coef_data,
`ifdef BABBAGE_STREAM_EN
    output logic                      stream_valid,
    output logic        [N_WIDTH-1:0] stream_idx,
    output logic signed [WIDTH-1:0]   stream_data,
`endif
    output logic                      ready,
    output logic signed [WIDTH-1:0]   babbage_out,
    output logic                      done_tick
);

    localparam int AW = (DEGREE > 1) ? $clog2(DEGREE + 1) : 1;
    localparam int CW = 4;

    typedef enum logic [2:0] {IDLE, EVAL, DIFF, RUN, DONE} state_t;

    state_t state, state_next;

    logic        [CW-1:0]      k, c, p;
    logic        [N_WIDTH-1:0] n_reg, run_cnt;
    logic signed [WIDTH-1:0]   coef [DEGREE+1];
    logic signed [WIDTH-1:0]   diff [DEGREE+1];
    logic signed [WIDTH-1:0]   acc, k_ext, horner;
    logic                      last_c, last_k, last_p, last_run;

    // One Horner step at point k; c selects the coefficient from the top down
    assign k_ext    = WIDTH'(k);
    assign horner   = acc * k_ext + coef[AW'(CW'(DEGREE) - c)];
    assign last_c   = (c == CW'(DEGREE));
    assign last_k   = (k == CW'(DEGREE));
    assign last_p   = (p == CW'(DEGREE));
    assign last_run = (run_cnt == n_reg - N_WIDTH'(1));
    assign ready    = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = EVAL;
            EVAL: if (last_c && last_k) state_next = DIFF;
            DIFF: begin
                if (last_p) state_next = (n_reg == '0) ? DONE : RUN;
            end
            RUN:  if (last_run) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= DEGREE; i++) begin
                coef[i] <= '0;
                diff[i] <= '0;
            end
            acc         <= '0;
            k           <= '0;
            c           <= '0;
            p           <= '0;
            n_reg       <= '0;
            run_cnt     <= '0;
            babbage_out <= '0;
            done_tick   <= 1'b0;
        end else begin
            done_tick <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (coef_we && coef_addr <= 4'(DEGREE))
                        coef[AW'(coef_addr)] <= coef_data;
                    if (start) begin
                        n_reg   <= n;
                        k       <= '0;
                        c       <= '0;
                        p       <= CW'(1);
                        run_cnt <= '0;
                    end
                end
                EVAL: begin
                    if (c == '0) acc <= coef[AW'(DEGREE)];
                    else         acc <= horner;
                    if (last_c) begin
                        diff[AW'(k)] <= horner;
                        c <= '0;
                        k <= k + CW'(1);
                    end else begin
                        c <= c + CW'(1);
                    end
                end
                DIFF: begin
                    // Pass p turns column i into the p-th difference for i >= p
                    for (int i = 1; i <= DEGREE; i++) begin
                        if (CW'(i) >= p) diff[i] <= diff[i] - diff[i-1];
                    end
                    p <= p + CW'(1);
                end
                RUN: begin
                    for (int i = 0; i < DEGREE; i++) begin
                        diff[i] <= diff[i] + diff[i+1];
                    end
                    run_cnt <= run_cnt + N_WIDTH'(1);
                end
                DONE: begin
                    babbage_out <= diff[0];
                    done_tick   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BABBAGE_STREAM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stream_valid <= 1'b0;
            stream_idx   <= '0;
            stream_data  <= '0;
        end else begin
            stream_valid <= 1'b0;
            if (state == DIFF && last_p) begin
                stream_valid <= 1'b1;
                stream_idx   <= '0;
                stream_data  <= diff[0];
            end else if (state == RUN) begin
                // Emit the value diff[0] takes at this edge
                stream_valid <= 1'b1;
                stream_idx   <= run_cnt + N_WIDTH'(1);
                stream_data  <= diff[0] + diff[1];
            end
        end
    end
`endif

endmodule

// File: tb/tb_babbage_engine_param.sv
// Scoreboard bench for babbage_engine_param (default DEGREE=5,
// plus a DEGREE=2 streaming instance when BABBAGE_STREAM_EN is set).
module tb_babbage_engine_param;

    typedef struct {
        int val;
        int due;
    } exp_t;

    logic               clk = 0;
    logic               rst = 1;
    logic               start = 0;
    logic [6:0]         n = '0;
    logic               coef_we = 0;
    logic [3:0]         coef_addr = '0;
    logic signed [31:0] coef_data = '0;
    logic               ready;
    logic signed [31:0] babbage_out;
    logic               done_tick;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef BABBAGE_STREAM_EN
    logic               sv_a;
    logic [6:0]         si_a;
    logic signed [31:0] sd_a;
`endif

    babbage_engine_param dut (
        .clk        (clk),
        .reset      (rst),
        .start      (start),
        .n          (n),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
`ifdef BABBAGE_STREAM_EN
        .stream_valid(sv_a),
        .stream_idx (si_a),
        .stream_data(sd_a),
`endif
        .ready      (ready),
        .babbage_out(babbage_out),
        .done_tick  (done_tick)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done_tick) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got out=%0d expected no done_tick",
                         babbage_out);
            end else begin
                e = q.pop_front();
                check("result", babbage_out, e.val);
                check("latency", cyc, e.due);
            end
        end
    end

    task automatic wr(input int addr, input int data);
        coef_we   = 1;
        coef_addr = 4'(addr);
        coef_data = 32'(data);
        @(posedge clk); #1;
        coef_we = 0;
    endtask

    task automatic kick(input int nval, input bit we, input int wa, input int wd);
        start     = 1;
        n         = 7'(nval);
        coef_we   = we;
        coef_addr = 4'(wa);
        coef_data = 32'(wd);
        @(posedge clk); #1;
        start   = 0;
        coef_we = 0;
    endtask

    task automatic go(input int nval, input int expv, input bit we, input int wa, input int wd);
        kick(nval, we, wa, wd);
        q.push_back('{expv, cyc + 42 + nval});
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (q.size() != 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got pending=%0d expected 0", q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic load_main();
        wr(5, -1); wr(4, 2); wr(3, 5); wr(2, 7); wr(1, 29); wr(0, 219);
    endtask

`ifdef BABBAGE_STREAM_EN
    typedef struct {
        int idx;
        int val;
    } sexp_t;

    logic               start_b = 0;
    logic [6:0]         n_b = '0;
    logic               coef_we_b = 0;
    logic [3:0]         coef_addr_b = '0;
    logic signed [31:0] coef_data_b = '0;
    logic               ready_b;
    logic signed [31:0] out_b;
    logic               done_b;
    logic               sv_b;
    logic [6:0]         si_b;
    logic signed [31:0] sd_b;
    sexp_t              sq[$];
    exp_t               qb[$];
    int                 last_s = 0;

    babbage_engine_param #(.DEGREE(2)) dut_b (
        .clk         (clk),
        .reset       (rst),
        .start       (start_b),
        .n           (n_b),
        .coef_we     (coef_we_b),
        .coef_addr   (coef_addr_b),
        .coef_data   (coef_data_b),
        .stream_valid(sv_b),
        .stream_idx  (si_b),
        .stream_data (sd_b),
        .ready       (ready_b),
        .babbage_out (out_b),
        .done_tick   (done_b)
    );

    always @(negedge clk) begin
        sexp_t s;
        exp_t  e;
        if (sv_b) begin
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_stream: got idx=%0d expected none", si_b);
            end else begin
                s = sq.pop_front();
                check("stream_idx", int'(si_b), s.idx);
                check("stream_data", sd_b, s.val);
                if (s.idx > 0) check("stream_gap", cyc - last_s, 1);
                last_s = cyc;
            end
        end
        if (done_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done_b: got out=%0d expected none", out_b);
            end else begin
                e = qb.pop_front();
                check("result_b", out_b, e.val);
                check("latency_b", cyc, e.due);
            end
        end
    end
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        check("rst_ready", int'(ready), 1);
        check("rst_out", babbage_out, 0);
        check("rst_done", int'(done_tick), 0);

        load_main();
        go(54, -441349395, 0, 0, 0);
        wait_done(300);

        // Write committed in the start cycle must be seen by that run
        go(0, 100, 1, 0, 100);
        wait_done(200);
        wr(0, 219);
        go(0, 219, 0, 0, 0);
        wait_done(200);

        // Out-of-range address must not alias onto coef[0]
        wr(8, 777);
        go(0, 219, 0, 0, 0);
        wait_done(200);

        // Start and write pulsed mid-RUN are ignored
        go(10, -73791, 0, 0, 0);
        repeat (49) @(posedge clk);
        #1;
        start = 1; n = 7'd0; coef_we = 1; coef_addr = 4'd0; coef_data = 32'sd5;
        @(posedge clk); #1;
        start = 0; coef_we = 0;
        wait_done(200);
        go(0, 219, 0, 0, 0);
        wait_done(200);

        for (int j = 0; j <= 5; j++) wr(j, 0);
        go(127, 0, 0, 0, 0);
        wait_done(400);
        wr(5, 1);
        go(127, -1321368961, 0, 0, 0);
        wait_done(400);

        // Asynchronous abort mid-RUN
        wr(0, 3);
        kick(100, 0, 0, 0);
        repeat (59) @(posedge clk);
        #1 rst = 1;
        #1;
        check("abort_ready", int'(ready), 1);
        check("abort_out", babbage_out, 0);
        check("abort_done", int'(done_tick), 0);
        @(posedge clk); #1 rst = 0;
        repeat (150) @(posedge clk);
        #1;
        check("post_abort_ready", int'(ready), 1);
        go(1, 0, 0, 0, 0);
        wait_done(200);

`ifdef BABBAGE_STREAM_EN
        coef_we_b = 1; coef_addr_b = 4'd2; coef_data_b = 32'sd1;
        @(posedge clk); #1;
        coef_we_b = 0;
        for (int j = 0; j <= 4; j++) sq.push_back('{j, j * j});
        start_b = 1; n_b = 7'd4;
        @(posedge clk); #1;
        start_b = 0;
        qb.push_back('{16, cyc + 16});
        for (int t = 0; t < 100 && (qb.size() != 0 || sq.size() != 0); t++)
            @(posedge clk);
        if (qb.size() != 0 || sq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout_b: got pending=%0d expected 0", qb.size() + sq.size());
        end
        @(posedge clk); #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
